// File: rtl/pipe_ctrl.sv
// Central pipeline control: stall/clear for if_id, id_ex, ex_mem and mem_wb,
// PC redirect with a pending slot for branches that resolve during a fetch.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no redirect outstanding; branches redirect immediately if fetch idle
// PENDING | branch seen while fetch busy; saved_target waits for fetch to finish
module pipe_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_stallreq,
  input  logic              id_stallreq,
  input  logic              mem_stallreq,
  input  logic              ex_branch,
  input  logic [ADDR_W-1:0] ex_branch_target,
  output logic              pc_stall,
  output logic              if_stall,
  output logic              if_clear,
  output logic              id_stall,
  output logic              id_clear,
  output logic              ex_stall,
  output logic              ex_clear,
  output logic              mem_stall,
  output logic              mem_clear,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] pc_target,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] saved_target;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;
  logic              latch_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      saved_target <= '0;
      stall_cnt    <= '0;
      flush_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (latch_target) saved_target <= ex_branch_target;
      if (pc_stall)     stall_cnt    <= stall_cnt + CNT_W'(1);
      if (pc_redirect)  flush_cnt    <= flush_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt    = state;
    latch_target = 1'b0;
    pc_stall     = 1'b0;
    if_stall     = 1'b0;
    if_clear     = 1'b0;
    id_stall     = 1'b0;
    id_clear     = 1'b0;
    ex_stall     = 1'b0;
    ex_clear     = 1'b0;
    mem_stall    = 1'b0;
    mem_clear    = 1'b0;
    pc_redirect  = 1'b0;
    pc_target    = (state == PENDING) ? saved_target : ex_branch_target;

    if (mem_stallreq) begin
      // Any branch in EX is frozen there and will re-assert once memory frees up.
      pc_stall  = 1'b1;
      if_stall  = 1'b1;
      id_stall  = 1'b1;
      ex_stall  = 1'b1;
      mem_clear = 1'b1;
    end else if (state == PENDING) begin
      if_clear = 1'b1;
      id_clear = 1'b1;
      if (if_stallreq) begin
        pc_stall = 1'b1;
      end else begin
        pc_redirect = 1'b1;
        state_nxt   = IDLE;
      end
    end else if (ex_branch) begin
      if_clear = 1'b1;
      id_clear = 1'b1;
      if (if_stallreq) begin
        pc_stall     = 1'b1;
        latch_target = 1'b1;
        state_nxt    = PENDING;
      end else begin
        pc_redirect = 1'b1;
      end
    end else if (id_stallreq) begin
      pc_stall = 1'b1;
      if_stall = 1'b1;
      id_clear = 1'b1;
    end else if (if_stallreq) begin
      pc_stall = 1'b1;
      if_clear = 1'b1;
    end

    // Everything reads as zero while reset is held, and nothing is latched.
    if (rst) begin
      state_nxt    = IDLE;
      latch_target = 1'b0;
      pc_stall     = 1'b0;
      if_stall     = 1'b0;
      if_clear     = 1'b0;
      id_stall     = 1'b0;
      id_clear     = 1'b0;
      ex_stall     = 1'b0;
      ex_clear     = 1'b0;
      mem_stall    = 1'b0;
      mem_clear    = 1'b0;
      pc_redirect  = 1'b0;
      pc_target    = '0;
    end
  end

  assign stall_cycles = rst ? '0 : stall_cnt;
  assign flush_count  = rst ? '0 : flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hand-computed control vectors, redirect
// targets and counter values checked with immediate assertions.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_stallreq, id_stallreq, mem_stallreq, ex_branch;
  logic [31:0] ex_branch_target;
  logic        pc_stall, if_stall, if_clear, id_stall, id_clear;
  logic        ex_stall, ex_clear, mem_stall, mem_clear, pc_redirect;
  logic [31:0] pc_target, stall_cycles, flush_count;

  int checks = 0;
  int errors = 0;

  localparam logic [9:0] C_PS = 10'h200, C_IS = 10'h100, C_IC = 10'h080,
                         C_DS = 10'h040, C_DC = 10'h020, C_ES = 10'h010,
                         C_EC = 10'h008, C_MS = 10'h004, C_MC = 10'h002,
                         C_RD = 10'h001;
  localparam logic [9:0] C_MEM = C_PS | C_IS | C_DS | C_ES | C_MC;

  pipe_ctrl #(.ADDR_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_stallreq(if_stallreq), .id_stallreq(id_stallreq),
    .mem_stallreq(mem_stallreq), .ex_branch(ex_branch),
    .ex_branch_target(ex_branch_target),
    .pc_stall(pc_stall), .if_stall(if_stall), .if_clear(if_clear),
    .id_stall(id_stall), .id_clear(id_clear), .ex_stall(ex_stall),
    .ex_clear(ex_clear), .mem_stall(mem_stall), .mem_clear(mem_clear),
    .pc_redirect(pc_redirect), .pc_target(pc_target),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] ctl();
    return {pc_stall, if_stall, if_clear, id_stall, id_clear,
            ex_stall, ex_clear, mem_stall, mem_clear, pc_redirect};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    if_stallreq = 1'b1; id_stallreq = 1'b1; mem_stallreq = 1'b1; ex_branch = 1'b1;
    ex_branch_target = 32'hFFFF_FFFF;

    for (int i = 0; i < 3; i++) begin
      settle();
      chk("rst_ctl", 32'(ctl()), 32'h0);
      chk("rst_target", pc_target, 32'h0);
      chk("rst_stallcnt", stall_cycles, 32'h0);
      chk("rst_flushcnt", flush_count, 32'h0);
      tick();
    end

    rst = 1'b0;
    if_stallreq = 1'b0; id_stallreq = 1'b0; mem_stallreq = 1'b0; ex_branch = 1'b0;
    ex_branch_target = 32'h0;
    settle();
    chk("idle_ctl", 32'(ctl()), 32'h0);
    tick();
    chk("idle_ctl2", 32'(ctl()), 32'h0);
    chk("idle_stallcnt", stall_cycles, 32'h0);
    chk("idle_flushcnt", flush_count, 32'h0);

    // Branch with fetch idle
    ex_branch = 1'b1; ex_branch_target = 32'h0000_0100;
    settle();
    chk("br_ctl", 32'(ctl()), 32'(C_RD | C_IC | C_DC));
    chk("br_target", pc_target, 32'h100);
    tick();
    ex_branch = 1'b0;
    settle();
    chk("br_flushcnt", flush_count, 32'd1);
    chk("br_stallcnt", stall_cycles, 32'd0);
    chk("br_after_ctl", 32'(ctl()), 32'h0);

    // Branch during fetch, target changes after first cycle
    ex_branch = 1'b1; ex_branch_target = 32'h200; if_stallreq = 1'b1;
    settle();
    chk("bf_c1_ctl", 32'(ctl()), 32'(C_PS | C_IC | C_DC));
    tick();
    ex_branch_target = 32'h300;
    settle();
    chk("bf_c2_ctl", 32'(ctl()), 32'(C_PS | C_IC | C_DC));
    chk("bf_c2_target", pc_target, 32'h200);
    tick();
    chk("bf_c3_ctl", 32'(ctl()), 32'(C_PS | C_IC | C_DC));
    tick();
    if_stallreq = 1'b0; ex_branch = 1'b0;
    settle();
    chk("bf_c4_ctl", 32'(ctl()), 32'(C_RD | C_IC | C_DC));
    chk("bf_c4_target", pc_target, 32'h200);
    tick();
    chk("bf_stallcnt", stall_cycles, 32'd3);
    chk("bf_flushcnt", flush_count, 32'd2);
    chk("bf_idle_ctl", 32'(ctl()), 32'h0);

    // Load-use hazard
    id_stallreq = 1'b1;
    settle();
    chk("lu_ctl", 32'(ctl()), 32'(C_PS | C_IS | C_DC));
    tick();
    id_stallreq = 1'b0;
    settle();
    chk("lu_stallcnt", stall_cycles, 32'd4);

    // Mem stall outranks a branch
    mem_stallreq = 1'b1; ex_branch = 1'b1; ex_branch_target = 32'h400;
    settle();
    chk("mem_c1_ctl", 32'(ctl()), 32'(C_MEM));
    tick();
    chk("mem_c2_ctl", 32'(ctl()), 32'(C_MEM));
    tick();
    mem_stallreq = 1'b0;
    settle();
    chk("mem_rel_ctl", 32'(ctl()), 32'(C_RD | C_IC | C_DC));
    chk("mem_rel_target", pc_target, 32'h400);
    tick();
    ex_branch = 1'b0;
    settle();
    chk("mem_stallcnt", stall_cycles, 32'd6);
    chk("mem_flushcnt", flush_count, 32'd3);

    // Fetch-only stall
    if_stallreq = 1'b1;
    settle();
    chk("fs_ctl", 32'(ctl()), 32'(C_PS | C_IC));
    tick();
    if_stallreq = 1'b0;

    // Mem stall defers a PENDING exit
    ex_branch = 1'b1; if_stallreq = 1'b1; ex_branch_target = 32'h500;
    tick();
    ex_branch = 1'b0; if_stallreq = 1'b0; mem_stallreq = 1'b1; ex_branch_target = 32'h0;
    settle();
    chk("pd_mem_ctl", 32'(ctl()), 32'(C_MEM));
    tick();
    mem_stallreq = 1'b0;
    settle();
    chk("pd_exit_ctl", 32'(ctl()), 32'(C_RD | C_IC | C_DC));
    chk("pd_exit_target", pc_target, 32'h500);
    tick();
    chk("pd_stallcnt", stall_cycles, 32'd9);
    chk("pd_flushcnt", flush_count, 32'd4);
    chk("pd_idle_ctl", 32'(ctl()), 32'h0);

    // Reset while PENDING discards the redirect
    ex_branch = 1'b1; if_stallreq = 1'b1; ex_branch_target = 32'h600;
    tick();
    rst = 1'b1; ex_branch = 1'b0;
    settle();
    chk("rp_rst_ctl", 32'(ctl()), 32'h0);
    chk("rp_rst_target", pc_target, 32'h0);
    tick();
    rst = 1'b0; if_stallreq = 1'b0;
    settle();
    chk("rp_ctl", 32'(ctl()), 32'h0);
    chk("rp_target", pc_target, 32'h600);
    chk("rp_stallcnt", stall_cycles, 32'd0);
    tick();
    chk("rp_ctl2", 32'(ctl()), 32'h0);
    chk("rp_flushcnt", flush_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
